// File: rtl/cdc_req_ack_rx.sv
// Receive endpoint of a four-phase REQ/ACK multi-bit crossing: captures the
// source word, hands it to local logic over valid/ready, and returns ACK.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for REQ_SYNC; ACK=0, OUT_VALID=0
// ST_VALID  | word captured and offered on OUT_DATA/OUT_VALID
// ST_ACK_HI | word consumed; ACK=1 until REQ_SYNC drops (or at once after an abort)
module cdc_req_ack_rx #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ_SYNC,
    input  logic [BUS_WIDTH-1:0] DATA_IN,
    input  logic                 OUT_READY,
    output logic [BUS_WIDTH-1:0] OUT_DATA,
    output logic                 OUT_VALID,
    output logic                 ACK,
    output logic                 BUSY,
    output logic                 ERR,
    output logic [CNT_WIDTH-1:0] XFER_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VALID  = 2'd1,
        ST_ACK_HI = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state, state_nxt;
    logic [BUS_WIDTH-1:0]   data_nxt;
    logic                   valid_nxt;
    logic                   ack_nxt;
    logic                   err_nxt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic                   abort, abort_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            ACK       <= 1'b0;
            ERR       <= 1'b0;
            XFER_CNT  <= '0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nxt;
            OUT_DATA  <= data_nxt;
            OUT_VALID <= valid_nxt;
            ACK       <= ack_nxt;
            ERR       <= err_nxt;
            XFER_CNT  <= cnt_nxt;
            abort     <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = OUT_DATA;
        valid_nxt = OUT_VALID;
        ack_nxt   = ACK;
        err_nxt   = ERR;
        cnt_nxt   = XFER_CNT;
        abort_nxt = abort;

        case (state)
            ST_IDLE: begin
                abort_nxt = 1'b0;
                if (REQ_SYNC) begin
                    data_nxt  = DATA_IN;
                    valid_nxt = 1'b1;
                    state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                // Early REQ drop is a source violation; remember it so ACK
                // is released without waiting on a REQ that already fell.
                if (!REQ_SYNC) begin
                    err_nxt   = 1'b1;
                    abort_nxt = 1'b1;
                end
                if (OUT_VALID && OUT_READY) begin
                    valid_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                    cnt_nxt   = XFER_CNT + CNT_ONE;
                    state_nxt = ST_ACK_HI;
                end
            end
            ST_ACK_HI: begin
                if (!REQ_SYNC || abort) begin
                    ack_nxt   = 1'b0;
                    abort_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                ack_nxt   = 1'b0;
                abort_nxt = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_cdc_req_ack_rx.sv
// Scoreboard bench for cdc_req_ack_rx: words queued when driven, popped when
// the consumer handshake is seen; cycle-level checks of ACK/ERR/XFER_CNT.
module tb_cdc_req_ack_rx;

    localparam int BW = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_SYNC;
    logic [BW-1:0] DATA_IN;
    logic          OUT_READY;
    logic [BW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          ACK;
    logic          BUSY;
    logic          ERR;
    logic [CW-1:0] XFER_CNT;

    int            n_cmp = 0;
    int            n_err = 0;
    int            n_xfer = 0;
    logic [BW-1:0] sb[$];

    cdc_req_ack_rx #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ_SYNC (REQ_SYNC),
        .DATA_IN  (DATA_IN),
        .OUT_READY(OUT_READY),
        .OUT_DATA (OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .ACK      (ACK),
        .BUSY     (BUSY),
        .ERR      (ERR),
        .XFER_CNT (XFER_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Consumer side of the scoreboard: inputs settle at posedge+1, so the
    // negedge sees exactly what the next posedge will sample.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(OUT_DATA), 32'hFFFF_FFFF);
            end else begin
                chk("sb_data", 32'(OUT_DATA), 32'(sb.pop_front()));
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_ack"},   32'(ACK), 0);
        chk({tag, "_busy"},  32'(BUSY), 0);
        chk({tag, "_valid"}, 32'(OUT_VALID), 0);
    endtask

    // Full transfer from IDLE: hold OUT_READY low for wait_cyc cycles after
    // OUT_VALID rises, keep REQ high for ack_hold edges in ACK_HI.
    task automatic xfer(input logic [BW-1:0] d, input int wait_cyc, input int ack_hold);
        DATA_IN   = d;
        REQ_SYNC  = 1'b1;
        OUT_READY = (wait_cyc == 0);
        sb.push_back(d);
        step();
        chk("valid_rise", 32'(OUT_VALID), 1);
        chk("data_cap",   32'(OUT_DATA), 32'(d));
        chk("busy_valid", 32'(BUSY), 1);
        for (int i = 0; i < wait_cyc; i++) begin
            OUT_READY = 1'b0;
            DATA_IN   = 8'h3C;
            step();
            chk("bp_valid", 32'(OUT_VALID), 1);
            chk("bp_data",  32'(OUT_DATA), 32'(d));
            chk("bp_ack",   32'(ACK), 0);
        end
        OUT_READY = 1'b1;
        n_xfer++;
        step();
        chk("xfer_valid", 32'(OUT_VALID), 0);
        chk("xfer_ack",   32'(ACK), 1);
        chk("xfer_cnt",   32'(XFER_CNT), 32'(n_xfer % (1 << CW)));
        OUT_READY = 1'b0;
        for (int i = 0; i < ack_hold; i++) begin
            step();
            chk("ack_hold", 32'(ACK), 1);
        end
        REQ_SYNC = 1'b0;
        step();
        check_idle("ack_fall");
    endtask

    initial begin
        RST       = 1'b1;
        REQ_SYNC  = 1'b0;
        DATA_IN   = '0;
        OUT_READY = 1'b0;
        step();
        chk("rst_data",  32'(OUT_DATA), 0);
        chk("rst_cnt",   32'(XFER_CNT), 0);
        chk("rst_err",   32'(ERR), 0);
        check_idle("rst");
        RST = 1'b0;
        step();

        // Single transfer, ready high throughout; ACK high for 2 cycles
        xfer(8'hA5, 0, 1);
        chk("single_cnt", 32'(XFER_CNT), 1);
        chk("single_err", 32'(ERR), 0);

        // Backpressure: 5 cycles of OUT_READY low, DATA_IN moves meanwhile
        xfer(8'hA5, 5, 1);

        // Back-to-back: REQ back up the cycle after ACK falls
        for (int i = 1; i <= 4; i++) xfer(8'(i), 0, 0);
        chk("b2b_cnt", 32'(XFER_CNT), 6);

        // Protocol error: REQ drops in VALID while stalled
        DATA_IN   = 8'h5A;
        REQ_SYNC  = 1'b1;
        OUT_READY = 1'b0;
        sb.push_back(8'h5A);
        step();
        chk("perr_valid0", 32'(OUT_VALID), 1);
        REQ_SYNC = 1'b0;
        step();
        chk("perr_err",   32'(ERR), 1);
        chk("perr_valid", 32'(OUT_VALID), 1);
        chk("perr_data",  32'(OUT_DATA), 32'h5A);
        chk("perr_ack0",  32'(ACK), 0);
        OUT_READY = 1'b1;
        n_xfer++;
        step();
        chk("perr_ack1",  32'(ACK), 1);
        chk("perr_cnt",   32'(XFER_CNT), 32'(n_xfer % (1 << CW)));
        // New request on the edge that leaves ACK_HI must not be taken
        OUT_READY = 1'b0;
        REQ_SYNC  = 1'b1;
        DATA_IN   = 8'h66;
        sb.push_back(8'h66);
        step();
        check_idle("perr_exit");
        step();
        chk("perr_next_valid", 32'(OUT_VALID), 1);
        chk("perr_next_data",  32'(OUT_DATA), 32'h66);
        OUT_READY = 1'b1;
        n_xfer++;
        step();
        chk("perr_next_ack", 32'(ACK), 1);
        OUT_READY = 1'b0;
        REQ_SYNC  = 1'b0;
        step();
        check_idle("perr_done");
        chk("perr_sticky", 32'(ERR), 1);

        // Reset while in ACK_HI with REQ still high
        DATA_IN   = 8'h11;
        REQ_SYNC  = 1'b1;
        OUT_READY = 1'b1;
        sb.push_back(8'h11);
        step();
        step();
        chk("mid_ack", 32'(ACK), 1);
        RST = 1'b1;
        step();
        n_xfer = 0;
        chk("mid_rst_data", 32'(OUT_DATA), 0);
        chk("mid_rst_cnt",  32'(XFER_CNT), 0);
        chk("mid_rst_err",  32'(ERR), 0);
        check_idle("mid_rst");
        RST       = 1'b0;
        OUT_READY = 1'b0;
        DATA_IN   = 8'h77;
        sb.push_back(8'h77);
        step();
        chk("mid_recap_valid", 32'(OUT_VALID), 1);
        chk("mid_recap_data",  32'(OUT_DATA), 32'h77);
        OUT_READY = 1'b1;
        n_xfer++;
        step();
        chk("mid_recap_ack", 32'(ACK), 1);
        OUT_READY = 1'b0;
        REQ_SYNC  = 1'b0;
        step();
        check_idle("mid_recap_done");

        // Counter wrap: 17 transfers since reset leaves XFER_CNT=1
        for (int i = 0; i < 16; i++)
            xfer(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
        chk("wrap_cnt", 32'(XFER_CNT), 1);
        chk("wrap_err", 32'(ERR), 0);

        // Ready and REQ drop on the same VALID edge: transfer and ERR together
        DATA_IN  = 8'hC3;
        REQ_SYNC = 1'b1;
        sb.push_back(8'hC3);
        step();
        REQ_SYNC  = 1'b0;
        OUT_READY = 1'b1;
        n_xfer++;
        step();
        chk("simul_err",   32'(ERR), 1);
        chk("simul_ack",   32'(ACK), 1);
        chk("simul_valid", 32'(OUT_VALID), 0);
        chk("simul_cnt",   32'(XFER_CNT), 2);
        OUT_READY = 1'b0;
        step();
        check_idle("simul_done");

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdc_req_ack_rx.md
# cdc_req_ack_rx

Receive-side endpoint of the four-phase REQ/ACK multi-bit clock-domain crossing. It consumes the request level already brought into this domain by a two-stage bit synchronizer, and captures the quasi-static source bus. It presents the word on a valid/ready interface to local logic and drives ACK back toward the source domain, where ACK is synchronized by a bit synchronizer of its own. It also counts completed transfers and flags protocol violations.

## Interface
- BUS_WIDTH, 8, width of the crossing data word
- CNT_WIDTH, 8, width of the completed-transfer counter

- CLK  in  1  destination-domain clock
- RST  in  1  reset; one clock, synchronous, active-high
- REQ_SYNC  in  1  source request, already synchronized into CLK domain
- DATA_IN  in  BUS_WIDTH  source data; held stable by source while its REQ is high
- OUT_READY  in  1  local consumer can accept OUT_DATA
- OUT_DATA  out  BUS_WIDTH  captured word, registered
- OUT_VALID  out  1  OUT_DATA valid, registered
- ACK  out  1  acknowledge to source domain, registered (glitch-free)
- BUSY  out  1  high whenever FSM is not IDLE
- ERR  out  1  sticky protocol-error flag
- XFER_CNT  out  CNT_WIDTH  count of completed transfers

## Operation
- FSM states and transitions:
  - IDLE: ACK=0, OUT_VALID=0.
    - REQ_SYNC=1 at an edge: OUT_DATA<=DATA_IN, OUT_VALID<=1, go VALID.
  - VALID: OUT_VALID=1, OUT_DATA frozen.
    - OUT_VALID&OUT_READY at an edge: OUT_VALID<=0, ACK<=1, XFER_CNT<=XFER_CNT+1, go ACK_HI.
  - ACK_HI: ACK=1.
    - REQ_SYNC=0 at an edge: ACK<=0, go IDLE.
- DATA_IN is sampled only on the IDLE->VALID edge and ignored at all other times.
- Protocol error: REQ_SYNC sampled 0 while in VALID sets ERR<=1.
  - The word is still delivered normally.
  - ACK_HI is then left on the first edge after it is entered.
  - ERR clears only on RST.
- XFER_CNT is modulo 2^CNT_WIDTH: all-ones+1 wraps to 0 with no flag.
- BUSY is decoded combinationally from the state register (state != IDLE).
- All outputs except BUSY are direct flop outputs.
- RST has priority over every transition.

## Timing
- Reset value on the first edge with RST=1: state IDLE; OUT_DATA=0, OUT_VALID=0, ACK=0, ERR=0, XFER_CNT=0, BUSY=0.
- Latency: REQ_SYNC first sampled high at edge N -> OUT_VALID=1 and OUT_DATA valid after edge N.
- Transfer edge M (OUT_VALID&OUT_READY) -> OUT_VALID=0, ACK=1 and XFER_CNT incremented, all after edge M.
- OUT_READY held high -> transfer edge is N+1.
- ACK falls after the first edge in ACK_HI with REQ_SYNC=0.
- Minimum of 3 cycles per transfer, counted in CLK edges IDLE->VALID->ACK_HI->IDLE.
- OUT_READY may be high before OUT_VALID; it has no effect outside VALID.
- OUT_READY low in VALID: hold indefinitely, with OUT_VALID, OUT_DATA and ACK unchanged.
- REQ_SYNC=1 on the same edge ACK_HI returns to IDLE: not accepted. The new request is accepted no earlier than the following edge.
- RST mid-transfer (VALID or ACK_HI): after that edge, every output is at its reset value. If REQ_SYNC is still 1 on the first edge after RST=0, it is accepted as a new request.
- Simultaneous OUT_READY=1 and REQ_SYNC=0 in VALID: transfer completes and ERR sets on the same edge.

## Test plan
- Single transfer, OUT_READY=1:
  - Stimulus: DATA_IN=0xA5; REQ_SYNC rises at edge 0 and falls 2 edges after ACK rises.
  - Required: OUT_VALID high for exactly 1 cycle with OUT_DATA=0xA5; ACK high for 2 cycles; XFER_CNT=1; ERR=0.
- Backpressure:
  - Stimulus: OUT_READY low for 5 cycles after OUT_VALID rises; DATA_IN changes to 0x3C during that window.
  - Required: OUT_VALID and OUT_DATA=0xA5 held for 5 cycles; ACK stays 0 until the transfer edge.
- Back-to-back:
  - Stimulus: 4 transfers 0x01..0x04, REQ_SYNC reasserted the cycle after ACK falls.
  - Required: words delivered in order; XFER_CNT=4; each OUT_VALID starts after the edge that samples REQ high in IDLE.
- Counter wrap:
  - Stimulus: CNT_WIDTH=4; 17 transfers.
  - Required: XFER_CNT=1 at the end; no ERR.
- Protocol error:
  - Stimulus: REQ_SYNC drops while in VALID with OUT_READY=0; OUT_READY then raised.
  - Required: ERR=1 after that edge; word still delivered; ACK high for 1 cycle; ERR stays 1 until RST.
- Reset mid-transfer:
  - Stimulus: RST pulsed for 1 cycle while in ACK_HI with REQ_SYNC=1.
  - Required: all outputs 0 after that edge; a new capture occurs on the first edge after RST drops.
